// File: rtl/data_sram_responder_if.sv
// ============================================================================
// Module   : data_sram_responder_if
// Purpose  : Data-side SRAM-like request/response bus (requester <-> responder).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_sram_responder_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

`default_nettype wire

// File: rtl/data_sram_responder.sv
// ============================================================================
// Module   : data_sram_responder
// Purpose  : Byte-writable word SRAM model answering in order after a fixed
//            latency. Optional macro DSRAM_RAND_DELAY_EN adds LFSR gating of addr_ok.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_sram_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    data_sram_responder_if.slave    bus
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_WORDS     = 1 << ADDR_W;
    localparam logic [2:0]         c_LOAD      = 3'(LATENCY - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE   = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_DEPTH = (c_PTR_W + 1)'(DEPTH);

    logic [31:0]        r_mem [c_WORDS];
    logic [31:0]        r_fifo_data [DEPTH];
    logic [2:0]         r_fifo_cnt [DEPTH];
    logic [DEPTH-1:0]   r_fifo_vld;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_addr_ok;

    logic               w_push;
    logic               w_pop;
    logic               w_gate;
    logic [c_PTR_W:0]   w_count_nxt;
    logic [ADDR_W-1:0]  w_idx;
    wire                w_unused_ok = ^{bus.data_sram_size,
                                        bus.data_sram_addr[31:ADDR_W+2],
                                        bus.data_sram_addr[1:0]};

    assign w_idx  = bus.data_sram_addr[ADDR_W+1:2];
    assign w_push = bus.data_sram_req & r_addr_ok;
    assign w_pop  = r_fifo_vld[r_rptr] & (r_fifo_cnt[r_rptr] == 3'd0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + c_CNT_ONE;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - c_CNT_ONE;
    end

`ifdef DSRAM_RAND_DELAY_EN
    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_nxt;

    // Fibonacci taps 8,6,5,4; addr_ok is registered, so gate on the next state
    assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_gate     = (w_lfsr_nxt[1:0] != 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_lfsr <= 8'h5A;
        else         r_lfsr <= w_lfsr_nxt;
    end
`else
    assign w_gate = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_addr_ok  <= 1'b0;
            r_fifo_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_data[i] <= 32'h0;
                r_fifo_cnt[i]  <= 3'd0;
            end
        end else begin
            r_count   <= w_count_nxt;
            // No pop bypass: acceptance depends on occupancy after this edge only
            r_addr_ok <= (w_count_nxt < c_CNT_DEPTH) & w_gate;
            for (int i = 0; i < DEPTH; i++) begin
                if (r_fifo_vld[i] && r_fifo_cnt[i] != 3'd0)
                    r_fifo_cnt[i] <= r_fifo_cnt[i] - 3'd1;
            end
            if (w_pop) begin
                r_fifo_vld[r_rptr] <= 1'b0;
                r_rptr             <= r_rptr + c_PTR_ONE;
            end
            if (w_push) begin
                r_fifo_vld[r_wptr]  <= 1'b1;
                r_fifo_cnt[r_wptr]  <= c_LOAD;
                r_fifo_data[r_wptr] <= bus.data_sram_wr ? 32'h0 : r_mem[w_idx];
                r_wptr              <= r_wptr + c_PTR_ONE;
            end
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (w_push && bus.data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wstrb[i])
                    r_mem[w_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
        end
    end

    assign bus.data_sram_addr_ok = r_addr_ok;
    assign bus.data_sram_data_ok = w_pop;
    assign bus.data_sram_rdata   = w_pop ? r_fifo_data[r_rptr] : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_data_sram_responder.sv
// ============================================================================
// Module   : tb_data_sram_responder
// Purpose  : Directed self-checking bench for data_sram_responder (defaults).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_sram_responder;

    localparam int c_LAT = 2;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;

    data_sram_responder_if bus ();

    data_sram_responder #(
        .ADDR_W  (12),
        .LATENCY (c_LAT),
        .DEPTH   (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request, then wait for its response and check latency and data
    task automatic do_req(input string tag, input logic wr, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp);
        int n;
        int lat;
        @(negedge clk);
        bus.data_sram_req   = 1'b1;
        bus.data_sram_wr    = wr;
        bus.data_sram_size  = 2'd2;
        bus.data_sram_wstrb = strb;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        n = 0;
        while (!bus.data_sram_addr_ok && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            bus.data_sram_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.data_sram_req = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.data_sram_data_ok && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'(c_LAT));
        check({tag, "_rdata"}, bus.data_sram_rdata, exp);
        @(negedge clk);
        check({tag, "_single_pulse"}, 32'(bus.data_sram_data_ok), 32'd0);
    endtask

    logic [31:0] burst_addr [4];
    logic [31:0] burst_data [4];
    logic [31:0] rx [$];
    logic [6:0]  ao_seq;
    logic [6:0]  dk_seq;
    int          k;
    int          pulses;
    logic        ok;

`ifdef DSRAM_RAND_DELAY_EN
    logic [31:0] model [16];
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetn = 1'b0;
        bus.data_sram_req   = 1'b0;
        bus.data_sram_wr    = 1'b0;
        bus.data_sram_size  = 2'd0;
        bus.data_sram_wstrb = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_addr_ok", 32'(bus.data_sram_addr_ok), 32'd0);
        check("rst_data_ok", 32'(bus.data_sram_data_ok), 32'd0);
        check("rst_rdata",   bus.data_sram_rdata, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        check("rel_addr_ok", 32'(bus.data_sram_addr_ok), 32'd1);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.data_sram_data_ok) pulses++;
        end
        check("idle_no_data_ok", 32'(pulses), 32'd0);
        check("idle_rdata", bus.data_sram_rdata, 32'h0);

        do_req("wr_word",   1'b1, 4'hF, 32'h100,  32'hDEADBEEF, 32'h0);
        do_req("rd_word",   1'b0, 4'h0, 32'h100,  32'h0,        32'hDEADBEEF);
        do_req("wr_byte",   1'b1, 4'b0010, 32'h101, 32'h0000_7700, 32'h0);
        do_req("rd_byte",   1'b0, 4'h0, 32'h100,  32'h0,        32'hDEAD77EF);
        do_req("wr_nostrb", 1'b1, 4'h0, 32'h100,  32'hFFFFFFFF, 32'h0);
        do_req("rd_nostrb", 1'b0, 4'h0, 32'h100,  32'h0,        32'hDEAD77EF);
        do_req("rd_alias",  1'b0, 4'h0, 32'h4103, 32'h0,        32'hDEAD77EF);

        burst_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        burst_data = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C};
        for (int i = 0; i < 4; i++)
            do_req("wr_pre", 1'b1, 4'hF, burst_addr[i], burst_data[i], 32'h0);

        // Held-request burst with DEPTH=2, LATENCY=2: exact per-cycle handshake
        @(negedge clk);
        bus.data_sram_req  = 1'b1;
        bus.data_sram_wr   = 1'b0;
        bus.data_sram_addr = burst_addr[0];
        k = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            if (cyc > 0) @(negedge clk);
            ao_seq[cyc] = bus.data_sram_addr_ok;
            dk_seq[cyc] = bus.data_sram_data_ok;
            if (bus.data_sram_data_ok) rx.push_back(bus.data_sram_rdata);
            ok = bus.data_sram_addr_ok & bus.data_sram_req;
            @(posedge clk);
            if (ok) begin
                k++;
                #1;
                if (k == 4) bus.data_sram_req = 1'b0;
                else        bus.data_sram_addr = burst_addr[k];
            end
        end
        check("burst_addr_ok_seq", 32'(ao_seq), 32'(7'b1011011));
        check("burst_data_ok_seq", 32'(dk_seq), 32'(7'b1101100));
        check("burst_accepted", 32'(k), 32'd4);
        check("burst_rx_count", 32'(rx.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("burst_rdata", (i < rx.size()) ? rx[i] : 32'hX, burst_data[i]);

        // Async reset with two reads in flight
        @(negedge clk);
        bus.data_sram_req  = 1'b1;
        bus.data_sram_addr = 32'h0;
        @(posedge clk);
        #1 bus.data_sram_addr = 32'h4;
        @(posedge clk);
        #1 bus.data_sram_req = 1'b0;
        #1 resetn = 1'b0;
        #1;
        check("arst_addr_ok", 32'(bus.data_sram_addr_ok), 32'd0);
        check("arst_data_ok", 32'(bus.data_sram_data_ok), 32'd0);
        check("arst_count",   32'(dut.r_count), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.data_sram_data_ok) pulses++;
        end
        check("arst_no_stale_data_ok", 32'(pulses), 32'd0);
        check("arst_addr_ok_back", 32'(bus.data_sram_addr_ok), 32'd1);
        do_req("rd_after_rst", 1'b0, 4'h0, 32'h100, 32'h0, 32'hDEAD77EF);

`ifdef DSRAM_RAND_DELAY_EN
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            do_req("rnd_init", 1'b1, 4'hF, 32'h200 + 32'(i * 4), model[i], 32'h0);
        end
        for (int n = 0; n < 200; n++) begin
            int          idx;
            logic        wr;
            logic [3:0]  strb;
            logic [31:0] wd;
            idx  = $urandom_range(0, 15);
            wr   = 1'($urandom_range(0, 1));
            strb = 4'($urandom);
            wd   = $urandom;
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
                do_req("rnd_wr", 1'b1, strb, 32'h200 + 32'(idx * 4), wd, 32'h0);
            end else begin
                do_req("rnd_rd", 1'b0, 4'h0, 32'h200 + 32'(idx * 4), 32'h0, model[idx]);
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
